// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART 8N1 receive front-end with a show-ahead receive FIFO, feeding the
//   memory-mapped UART port of the core.
//
//   Ports
//     clk           system clock, rising edge
//     reset         asynchronous, active-high reset
//     SerialDataIn  UART line (idles high, asynchronous to clk)
//     clr_rx_flag   pop request; every cycle it is high pops one entry
//     clr_err       clears the sticky frame_err / overrun flags
//     DataRx        FIFO head byte (valid while Rx_flag is high)
//     Rx_flag       FIFO not empty
//     frame_err     sticky: a stop bit was sampled low
//     overrun       sticky: a byte was dropped because the FIFO was full
//     fifo_count    current FIFO occupancy
//
//   Receiver states
//     state   | meaning
//     S_IDLE  | waiting for a falling edge on the synchronised line
//     S_START | timing to mid start bit; high there means a glitch
//     S_DATA  | sampling data bits LSB first, one per bit period
//     S_STOP  | sampling the stop bit; push the byte or flag a frame error

module uart_rx_fifo #(
    parameter int UART_Nbit  = 8,
    parameter int clk_freq   = 50,
    parameter int baudrate   = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          SerialDataIn,
    input  logic                          clr_rx_flag,
    input  logic                          clr_err,
    output logic [UART_Nbit-1:0]          DataRx,
    output logic                          Rx_flag,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BIT_CYCLES = clk_freq / baudrate;
    localparam int TMR_W      = $clog2(BIT_CYCLES);
    localparam int IDX_W      = (UART_Nbit > 1) ? $clog2(UART_Nbit) : 1;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    localparam logic [TMR_W-1:0] HALF_TC  = TMR_W'(BIT_CYCLES / 2 - 1);
    localparam logic [TMR_W-1:0] BIT_TC   = TMR_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_Nbit - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Synchroniser
    logic sync1_q, sync2_q;
    logic rxs;

    // Receiver
    state_t               state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [UART_Nbit-1:0] shift_q, shift_d;
    logic                 push_req;
    logic                 frame_evt;

    // FIFO
    logic [UART_Nbit-1:0] mem_q [FIFO_DEPTH];
    logic [UART_Nbit-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 pop;
    logic                 full;
    logic                 do_push;
    logic                 ovr_evt;

    // Sticky error flags
    logic frame_err_q, frame_err_d;
    logic overrun_q, overrun_d;

    assign rxs = sync2_q;

    // ------------------------------------------------------------------
    // Receiver next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + TMR_W'(1);
        idx_d     = idx_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        frame_evt = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (!rxs) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (timer_q == HALF_TC) begin
                    timer_d = '0;
                    idx_d   = '0;
                    // Line back high at mid start bit: noise, not a frame.
                    state_d = rxs ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                if (timer_q == BIT_TC) begin
                    shift_d[idx_q] = rxs;
                    timer_d        = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            S_STOP: begin
                if (timer_q == BIT_TC) begin
                    // Leave immediately after the mid-stop sample so a
                    // following start bit is not missed.
                    timer_d = '0;
                    state_d = S_IDLE;
                    if (rxs) begin
                        push_req = 1'b1;
                    end else begin
                        frame_evt = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO and error flag next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        pop     = clr_rx_flag && (count_q != '0);
        full    = (count_q == FULL_CNT);
        // When full, a same-cycle pop frees the head slot, which is exactly
        // the slot wr_ptr points at, so the write lands in the right place.
        do_push = push_req && (!full || pop);
        ovr_evt = push_req && full && !pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({do_push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Set has priority over clear.
        frame_err_d = frame_err_q;
        if (clr_err) begin
            frame_err_d = 1'b0;
        end
        if (frame_evt) begin
            frame_err_d = 1'b1;
        end

        overrun_d = overrun_q;
        if (clr_err) begin
            overrun_d = 1'b0;
        end
        if (ovr_evt) begin
            overrun_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= S_IDLE;
            timer_q     <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= SerialDataIn;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign DataRx     = mem_q[rd_ptr_q];
    assign Rx_flag    = (count_q != '0);
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo at default parameters (10 clocks/bit,
//   4-entry FIFO). Bytes are queued as expected when their frame is driven
//   and compared in order as they are popped from the DUT.

module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       SerialDataIn;
    logic       clr_rx_flag;
    logic       clr_err;
    logic [7:0] DataRx;
    logic       Rx_flag;
    logic       frame_err;
    logic       overrun;
    logic [2:0] fifo_count;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    int         model_count = 0;
    logic       model_ovr   = 1'b0;
    bit         abort_tx    = 1'b0;
    logic [7:0] head;

    uart_rx_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .SerialDataIn(SerialDataIn),
        .clr_rx_flag (clr_rx_flag),
        .clr_err     (clr_err),
        .DataRx      (DataRx),
        .Rx_flag     (Rx_flag),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks = n_checks + 1;
        assert (obs === expv) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    // One 8N1 frame, 10 clocks per bit, then one idle-high clock.
    task automatic send_byte(input logic [7:0] data, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, data, 1'b0};
        if (stop_bit) begin
            if (model_count < 4) begin
                exp_q.push_back(data);
                model_count = model_count + 1;
            end else begin
                model_ovr = 1'b1;
            end
        end
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (abort_tx) break;
            SerialDataIn = frame[c / 10];
        end
        @(posedge clk); #1;
        SerialDataIn = 1'b1;
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        e = exp_q.pop_front();
        model_count = model_count - 1;
        @(negedge clk);
        check({tag, " flag"}, 32'(Rx_flag), 32'd1);
        check({tag, " data"}, 32'(DataRx), 32'(e));
        @(posedge clk); #1 clr_rx_flag = 1'b1;
        @(posedge clk); #1 clr_rx_flag = 1'b0;
    endtask

    task automatic pulse_clr_err();
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        SerialDataIn = 1'b1;
        clr_rx_flag  = 1'b0;
        clr_err      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst flag",  32'(Rx_flag),    32'd0);
        check("rst count", 32'(fifo_count), 32'd0);
        check("rst ferr",  32'(frame_err),  32'd0);
        check("rst ovr",   32'(overrun),    32'd0);
        check("rst data",  32'(DataRx),     32'd0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (5) @(posedge clk);

        // Single byte 0x39 with exact push latency
        fork
            send_byte(8'h39, 1'b1);
            begin
                repeat (98) @(posedge clk);
                @(negedge clk);
                check("lat before", 32'(fifo_count), 32'd0);
                @(negedge clk);
                check("lat after",  32'(fifo_count), 32'd1);
                check("lat flag",   32'(Rx_flag),    32'd1);
            end
        join
        @(negedge clk);
        check("b1 ferr", 32'(frame_err), 32'd0);
        pop_check("b1");
        @(negedge clk);
        check("b1 empty flag",  32'(Rx_flag),    32'd0);
        check("b1 empty count", 32'(fifo_count), 32'd0);

        // Pop while empty is ignored
        @(posedge clk); #1 clr_rx_flag = 1'b1;
        @(posedge clk); #1 clr_rx_flag = 1'b0;
        @(negedge clk);
        check("emptypop count", 32'(fifo_count), 32'd0);
        check("emptypop ovr",   32'(overrun),    32'd0);

        // Short low glitch on an idle line
        @(posedge clk); #1 SerialDataIn = 1'b0;
        repeat (3) @(posedge clk);
        #1 SerialDataIn = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("glitch flag", 32'(Rx_flag),   32'd0);
        check("glitch ferr", 32'(frame_err), 32'd0);
        check("glitch ovr",  32'(overrun),   32'd0);

        // Framing error
        send_byte(8'hA5, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("ferr set",   32'(frame_err),  32'd1);
        check("ferr count", 32'(fifo_count), 32'd0);
        pulse_clr_err();
        @(negedge clk);
        check("ferr clr", 32'(frame_err), 32'd0);

        // Overrun: five bytes into a four-entry FIFO
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("ovr count", 32'(fifo_count), 32'(model_count));
        check("ovr flag",  32'(overrun),    32'(model_ovr));
        pop_check("ovr pop0");
        pop_check("ovr pop1");
        pop_check("ovr pop2");
        pop_check("ovr pop3");
        @(negedge clk);
        check("ovr drained", 32'(Rx_flag), 32'd0);
        pulse_clr_err();
        model_ovr = 1'b0;
        @(negedge clk);
        check("ovr clr", 32'(overrun), 32'(model_ovr));

        // Full FIFO with a pop in the exact push cycle
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        @(negedge clk);
        check("pp full", 32'(fifo_count), 32'd4);
        head = exp_q.pop_front();
        model_count = model_count - 1;
        fork
            send_byte(8'h66, 1'b1);
            begin
                repeat (98) @(posedge clk);
                #1 clr_rx_flag = 1'b1;
                @(negedge clk);
                check("pp head", 32'(DataRx), 32'(head));
                @(posedge clk); #1 clr_rx_flag = 1'b0;
            end
        join
        @(negedge clk);
        check("pp ovr",   32'(overrun),    32'd0);
        check("pp count", 32'(fifo_count), 32'(model_count));
        pop_check("pp pop0");
        pop_check("pp pop1");
        pop_check("pp pop2");
        pop_check("pp pop3");

        // Reset in the middle of a frame
        fork
            send_byte(8'h39, 1'b1);
            begin
                repeat (40) @(posedge clk);
                #1 reset = 1'b1;
                abort_tx = 1'b1;
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("mid rst count", 32'(fifo_count), 32'd0);
                check("mid rst data",  32'(DataRx),     32'd0);
                @(posedge clk); #1 reset = 1'b0;
            end
        join
        exp_q.delete();
        model_count = 0;
        abort_tx = 1'b0;
        repeat (20) @(posedge clk);
        send_byte(8'h7E, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("post rst count", 32'(fifo_count), 32'd1);
        check("post rst ferr",  32'(frame_err),  32'd0);
        pop_check("post rst");
        @(negedge clk);
        check("post rst empty", 32'(Rx_flag), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
